// File: rtl/sub4_pkg.sv
// Shared types and sizing helpers for the nibble-serial subtractor.
package sub4_pkg;

    localparam int unsigned NIBBLE_W = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } sub_state_t;

    // Number of nibble passes needed for a given operand width.
    function automatic int unsigned nib_count(input int unsigned width);
        return width / NIBBLE_W;
    endfunction

endpackage

// File: rtl/sub4_cla.sv
// Combinational 4-bit borrow-lookahead subtract slice: d = a - b - bin.
module sub4_cla
    import sub4_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                bin,
    output logic [NIBBLE_W-1:0] d,
    output logic                bout
);

    logic [NIBBLE_W-1:0] g;
    logic [NIBBLE_W-1:0] p;
    logic [NIBBLE_W-1:0] bc;

    // Generate: this bit borrows on its own; propagate: equal bits pass the incoming borrow.
    assign g = ~a & b;
    assign p = ~(a ^ b);

    // Every internal borrow is a flat sum of products of g/p and bin.
    assign bc[0] = bin;
    assign bc[1] = g[0] | (p[0] & bin);
    assign bc[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bin);
    assign bc[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                 | (p[2] & p[1] & p[0] & bin);
    assign bout  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                 | (p[3] & p[2] & p[1] & g[0])
                 | (p[3] & p[2] & p[1] & p[0] & bin);

    assign d = a ^ b ^ bc;

endmodule

// File: rtl/sub4_serial_subtractor.sv
// Multi-cycle subtractor: diff = a - b - borrow_i, one nibble per clock through a single slice.
module sub4_serial_subtractor
    import sub4_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             borrow_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] diff_o,
    output logic             borrow_o,
    output logic             overflow_o
);

    localparam int unsigned NIB      = nib_count(WIDTH);
    localparam int unsigned CNT_W    = (NIB > 1) ? $clog2(NIB) : 1;
    localparam int unsigned DSH_W    = WIDTH - NIBBLE_W;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIB - 1);

    if (((WIDTH % NIBBLE_W) != 0) || (WIDTH < 8)) begin : g_bad_width
        $fatal(1, "sub4_serial_subtractor: WIDTH must be a multiple of 4 and >= 8");
    end

    sub_state_t state_q;
    sub_state_t state_d;

    logic [WIDTH-1:0]    a_sh_q;
    logic [WIDTH-1:0]    b_sh_q;
    logic [DSH_W-1:0]    diff_sh_q;
    logic                borrow_q;
    logic [CNT_W-1:0]    cnt_q;

    logic                accept_c;
    logic                step_c;
    logic                last_c;

    logic [NIBBLE_W-1:0] nib_d;
    logic                nib_bout;
    logic [WIDTH-1:0]    diff_nx;

    sub4_cla u_cla (
        .a    (a_sh_q[NIBBLE_W-1:0]),
        .b    (b_sh_q[NIBBLE_W-1:0]),
        .bin  (borrow_q),
        .d    (nib_d),
        .bout (nib_bout)
    );

    // New nibble enters from the MSB side; after NIB steps the word is aligned.
    assign diff_nx = {nib_d, diff_sh_q};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        accept_c = 1'b0;
        step_c   = 1'b0;
        last_c   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (in_valid_i) begin
                    accept_c = 1'b1;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                step_c = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    last_c  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Datapath, handshake flags and result registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            diff_sh_q   <= '0;
            borrow_q    <= 1'b0;
            cnt_q       <= '0;
            in_ready_o  <= 1'b1;
            out_valid_o <= 1'b0;
            diff_o      <= '0;
            borrow_o    <= 1'b0;
            overflow_o  <= 1'b0;
        end else begin
            in_ready_o  <= (state_d == S_IDLE);
            out_valid_o <= (state_d == S_DONE);
            if (accept_c) begin
                a_sh_q    <= a_i;
                b_sh_q    <= b_i;
                borrow_q  <= borrow_i;
                diff_sh_q <= '0;
                cnt_q     <= '0;
            end
            if (step_c) begin
                a_sh_q    <= {NIBBLE_W'(0), a_sh_q[WIDTH-1:NIBBLE_W]};
                b_sh_q    <= {NIBBLE_W'(0), b_sh_q[WIDTH-1:NIBBLE_W]};
                diff_sh_q <= diff_nx[WIDTH-1:NIBBLE_W];
                borrow_q  <= nib_bout;
                cnt_q     <= cnt_q + CNT_W'(1);
            end
            // On the final pass the slice holds the operand MSBs, so overflow comes from it.
            if (last_c) begin
                diff_o     <= diff_nx;
                borrow_o   <= nib_bout;
                overflow_o <= (a_sh_q[NIBBLE_W-1] != b_sh_q[NIBBLE_W-1])
                           && (nib_d[NIBBLE_W-1] != a_sh_q[NIBBLE_W-1]);
            end
        end
    end

endmodule

// File: tb/tb_sub4_serial_subtractor.sv
// Randomised bench for sub4_serial_subtractor (WIDTH=16) against an arithmetic reference model.
module tb_sub4_serial_subtractor;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned NIB   = WIDTH / 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             borrow_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
    logic             overflow;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    sub4_serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .a_i         (a_in),
        .b_i         (b_in),
        .borrow_i    (borrow_in),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .diff_o      (diff),
        .borrow_o    (borrow_out),
        .overflow_o  (overflow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic; returns {overflow, borrow, diff}.
    function automatic logic [WIDTH+1:0] ref_sub(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b,
                                                 input logic bin);
        int unsigned ua;
        int unsigned ub;
        int          sd;
        logic [WIDTH-1:0] d;
        logic bo;
        logic ov;
        ua = 32'(a);
        ub = 32'(b);
        d  = WIDTH'(ua - ub - 32'(bin));
        bo = (ua < ub + 32'(bin));
        sd = int'($signed(a)) - int'($signed(b)) - int'({31'd0, bin});
        ov = (sd < -32768) || (sd > 32767);
        return {ov, bo, d};
    endfunction

    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic bin, input int unsigned stall, input bit garbage);
        logic [WIDTH+1:0] exp;
        int unsigned cyc;
        exp       = ref_sub(a, b, bin);
        in_valid  = 1'b1;
        a_in      = a;
        b_in      = b;
        borrow_in = bin;
        cyc = 0;
        while (!in_ready && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (!in_ready) begin
            check("accept_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        in_valid = garbage;
        if (garbage) begin
            a_in      = WIDTH'($urandom);
            b_in      = WIDTH'($urandom);
            borrow_in = 1'($urandom);
        end
        check("ready_low_run", 32'(in_ready), 32'd0);
        cyc = 0;
        while (!out_valid && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("latency", cyc, NIB);
        check("diff", 32'(diff), 32'(exp[WIDTH-1:0]));
        check("borrow", 32'(borrow_out), 32'(exp[WIDTH]));
        check("overflow", 32'(overflow), 32'(exp[WIDTH+1]));
        for (int i = 0; i < int'(stall); i++) begin
            @(posedge clk); #1;
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_ready", 32'(in_ready), 32'd0);
        end
        if (stall > 0) check("stall_diff", 32'(diff), 32'(exp[WIDTH-1:0]));
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("idle_valid", 32'(out_valid), 32'd0);
        check("idle_ready", 32'(in_ready), 32'd1);
        check("idle_hold", 32'({overflow, borrow_out, diff}), 32'(exp));
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a_in      = '0;
        b_in      = '0;
        borrow_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_outs", 32'({overflow, borrow_out, diff}), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(16'h1234, 16'h0234, 1'b0, 0, 1'b0);
        run_op(16'h0000, 16'h0001, 1'b0, 1, 1'b0);
        run_op(16'h5555, 16'h5555, 1'b1, 0, 1'b0);
        run_op(16'h8000, 16'h0001, 1'b0, 2, 1'b0);
        run_op(16'h7FFF, 16'hFFFF, 1'b0, 0, 1'b0);
        run_op(16'hFFFF, 16'h0000, 1'b0, 0, 1'b0);

        // Long backpressure with operand pulses that must be ignored.
        run_op(16'hA5C3, 16'h3C5A, 1'b1, 10, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check("no_phantom_op", 32'(out_valid), 32'd0);

        // Reset during the second RUN cycle aborts the operation.
        in_valid  = 1'b1;
        a_in      = 16'h4321;
        b_in      = 16'h1234;
        borrow_in = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midrun_rst_valid", 32'(out_valid), 32'd0);
        check("midrun_rst_ready", 32'(in_ready), 32'd1);
        check("midrun_rst_outs", 32'({overflow, borrow_out, diff}), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_valid", 32'(out_valid), 32'd0);
        run_op(16'h00FF, 16'h000F, 1'b0, 0, 1'b0);

        for (int n = 0; n < 2000; n++) begin
            logic [WIDTH-1:0] ra;
            logic [WIDTH-1:0] rb;
            ra = WIDTH'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? ra : WIDTH'($urandom);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            run_op(ra, rb, 1'($urandom), $urandom_range(0, 3), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
